// File: rtl/serial_audio_encoder_if.sv
// Sample stream into the serial audio encoder: one { is_left, audio } word per handshake.
// i_ready is a function of i_is_left only, so a source may present a word and wait for it.
interface serial_audio_encoder_if #(
    parameter int audio_width = 16
);
    logic                   i_valid;
    logic                   i_ready;
    logic                   i_is_left;
    logic [audio_width-1:0] i_audio;

    modport master (
        output i_valid,
        output i_is_left,
        output i_audio,
        input  i_ready
    );

    modport slave (
        input  i_valid,
        input  i_is_left,
        input  i_audio,
        output i_ready
    );
endinterface

// File: rtl/serial_audio_encoder.sv
// I2S / left-justified serial audio master; optional SERIAL_AUDIO_ENCODER_HOLD_LAST_EN repeats the last word on underrun.
// Latency: a sample accepted >= 1 cycle before its channel's load edge is output in that slot (MSB at p=0 LJ, p=1 I2S).
// Backpressure: one holding register per channel; i_ready drops for a channel while its register is full.
module serial_audio_encoder #(
    parameter int audio_width = 16,
    parameter int slot_width  = 32
) (
    input  logic                  sclk,
    input  logic                  nreset,
    input  logic                  is_i2s,
    input  logic                  lrclk_polarity,
    serial_audio_encoder_if.slave in_if,
    output logic                  lrclk,
    output logic                  sdout,
    output logic                  is_underrun
);
    localparam int pw = (slot_width > 1) ? $clog2(slot_width) : 1;

    generate
        if (slot_width < audio_width + 1) begin : g_bad_slot_width
            $error("serial_audio_encoder: slot_width must be >= audio_width+1");
        end
    endgenerate

    logic [pw-1:0]          pos;
    logic                   started;
    logic                   cur_right;
    logic                   i2s_q;
    logic                   pol_q;
    logic                   full_l;
    logic                   full_r;
    logic [audio_width-1:0] hold_l;
    logic [audio_width-1:0] hold_r;
    logic [audio_width-1:0] shreg;
`ifdef SERIAL_AUDIO_ENCODER_HOLD_LAST_EN
    logic [audio_width-1:0] last_l;
    logic [audio_width-1:0] last_r;
`endif

    logic                   accept_l;
    logic                   accept_r;
    logic                   load;
    logic                   load_right;
    logic                   load_full;
    logic [audio_width-1:0] hold_word;
    logic [audio_width-1:0] word;
    logic                   mode_i2s;
    logic                   mode_pol;

    assign in_if.i_ready = in_if.i_is_left ? !full_l : !full_r;
    assign accept_l      = in_if.i_valid && in_if.i_ready && in_if.i_is_left;
    assign accept_r      = in_if.i_valid && in_if.i_ready && !in_if.i_is_left;

    // Before the first load edge 'started' is low: that edge opens a left slot of zeros, never an underrun.
    always_comb begin
        load       = !started || (pos == pw'(slot_width - 1));
        load_right = started && !cur_right;
        load_full  = load_right ? full_r : full_l;
        hold_word  = load_right ? hold_r : hold_l;
        mode_i2s   = (load && !load_right) ? is_i2s : i2s_q;
        mode_pol   = (load && !load_right) ? lrclk_polarity : pol_q;
        if (!started) begin
            word = '0;
        end else if (load_full) begin
            word = hold_word;
        end else begin
`ifdef SERIAL_AUDIO_ENCODER_HOLD_LAST_EN
            word = load_right ? last_r : last_l;
`else
            word = '0;
`endif
        end
    end

    always_ff @(posedge sclk) begin
        if (!nreset) begin
            pos         <= '0;
            started     <= 1'b0;
            cur_right   <= 1'b0;
            i2s_q       <= is_i2s;
            pol_q       <= lrclk_polarity;
            full_l      <= 1'b0;
            full_r      <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            shreg       <= '0;
            lrclk       <= lrclk_polarity;
            sdout       <= 1'b0;
            is_underrun <= 1'b0;
`ifdef SERIAL_AUDIO_ENCODER_HOLD_LAST_EN
            last_l      <= '0;
            last_r      <= '0;
`endif
        end else begin
            started <= 1'b1;
            // A same-edge accept into the channel being loaded lands after the clear: it waits for the next slot.
            full_l  <= (full_l && !(load && started && !load_right)) || accept_l;
            full_r  <= (full_r && !(load && load_right)) || accept_r;
            if (accept_l) begin
                hold_l <= in_if.i_audio;
            end
            if (accept_r) begin
                hold_r <= in_if.i_audio;
            end
            if (load) begin
                pos         <= '0;
                cur_right   <= load_right;
                i2s_q       <= mode_i2s;
                pol_q       <= mode_pol;
                lrclk       <= load_right ^ mode_pol;
                is_underrun <= started && !load_full;
                if (mode_i2s) begin
                    sdout <= 1'b0;
                    shreg <= word;
                end else begin
                    sdout <= word[audio_width-1];
                    shreg <= {word[audio_width-2:0], 1'b0};
                end
`ifdef SERIAL_AUDIO_ENCODER_HOLD_LAST_EN
                if (started && load_full) begin
                    if (load_right) begin
                        last_r <= hold_word;
                    end else begin
                        last_l <= hold_word;
                    end
                end
`endif
            end else begin
                pos         <= pos + 1'b1;
                is_underrun <= 1'b0;
                sdout       <= shreg[audio_width-1];
                shreg       <= {shreg[audio_width-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_serial_audio_encoder.sv
// Scoreboard bench for serial_audio_encoder: expected slots are queued per phase, a monitor deserialises each slot.
// The monitor decodes sdout/lrclk like a receiver on the same sclk and checks word, lrclk, padding and underrun pulse.
module tb_serial_audio_encoder;
    localparam int AW = 16;
    localparam int SW = 32;
`ifdef SERIAL_AUDIO_ENCODER_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic          right;
        logic [AW-1:0] word;
        logic          ur;
        logic          i2s;
        logic          pol;
    } slot_t;

    logic sclk;
    logic nreset;
    logic is_i2s;
    logic lrclk_polarity;
    logic lrclk;
    logic sdout;
    logic is_underrun;

    serial_audio_encoder_if #(.audio_width(AW)) bus ();

    serial_audio_encoder #(.audio_width(AW), .slot_width(SW)) dut (
        .sclk           (sclk),
        .nreset         (nreset),
        .is_i2s         (is_i2s),
        .lrclk_polarity (lrclk_polarity),
        .in_if          (bus),
        .lrclk          (lrclk),
        .sdout          (sdout),
        .is_underrun    (is_underrun)
    );

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    bit    mon_en = 1'b0;
    slot_t exp_q[$];

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(posedge sclk) cyc <= nreset ? cyc + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] ramp(input int i);
        return AW'(i * 1021 + 7);
    endfunction

    task automatic push_slot(input logic right, input logic [AW-1:0] w, input logic ur);
        slot_t s;
        s.right = right;
        s.word  = w;
        s.ur    = ur;
        s.i2s   = is_i2s;
        s.pol   = lrclk_polarity;
        exp_q.push_back(s);
    endtask

    // Present one word and hold it until accepted; returns the edge number of the handshake.
    task automatic send(input logic left, input logic [AW-1:0] w, output int acc_edge);
        int n = 0;
        bus.i_valid   = 1'b1;
        bus.i_is_left = left;
        bus.i_audio   = w;
        @(negedge sclk);
        while (!bus.i_ready && n < 400) begin
            @(negedge sclk);
            n++;
        end
        if (!bus.i_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready still 0 after %0d cycles, required 1", n);
            acc_edge = -1;
        end else begin
            acc_edge = cyc + 1;
            @(posedge sclk);
            #1;
        end
        bus.i_valid = 1'b0;
    endtask

    // Reset for 3 edges with the given mode, check reset outputs, then release; returns just after the first load edge.
    task automatic do_reset(input logic i2s, input logic pol);
        nreset         = 1'b0;
        mon_en         = 1'b0;
        is_i2s         = i2s;
        lrclk_polarity = pol;
        bus.i_valid    = 1'b0;
        check("slots_consumed", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        check("rst_lrclk", {31'd0, lrclk}, {31'd0, pol});
        check("rst_sdout", {31'd0, sdout}, 32'd0);
        check("rst_underrun", {31'd0, is_underrun}, 32'd0);
        bus.i_is_left = 1'b1;
        #1 check("rst_ready_left", {31'd0, bus.i_ready}, 32'd1);
        bus.i_is_left = 1'b0;
        #1 check("rst_ready_right", {31'd0, bus.i_ready}, 32'd1);
        @(posedge sclk);
        #1 nreset = 1'b1;
        @(posedge sclk);
        #1 mon_en = 1'b1;
    endtask

    // Let nslots whole slots run (counted from the first load edge), then extra cycles into the next one.
    task automatic run_slots(input int nslots, input int extra);
        repeat (SW * nslots - 1) @(posedge sclk);
        @(negedge sclk);
        #1;
        repeat (extra) @(posedge sclk);
        #1;
        mon_en = 1'b0;
        nreset = 1'b0;
    endtask

    initial begin : monitor
        int            p = 0;
        int            off = 0;
        int            d;
        bit            have = 1'b0;
        logic [AW-1:0] acc = '0;
        logic          lr_exp = 1'b0;
        bit            lr_bad = 1'b0;
        bit            ur0 = 1'b0;
        bit            ur_other = 1'b0;
        bit            pad = 1'b0;
        slot_t         e;
        forever begin
            @(negedge sclk);
            if (!mon_en) begin
                p = 0;
            end else begin
                if (p == 0) begin
                    acc = '0; lr_bad = 0; ur0 = 0; ur_other = 0; pad = 0;
                    have = (exp_q.size() > 0);
                    if (have) begin
                        e      = exp_q[0];
                        off    = e.i2s ? 1 : 0;
                        lr_exp = e.right ^ e.pol;
                    end
                end
                d = p - off;
                if (d >= 0 && d < AW) acc[AW-1-d] = sdout;
                else if (sdout) pad = 1'b1;
                if (have && lrclk !== lr_exp) lr_bad = 1'b1;
                if (is_underrun) begin
                    if (p == 0) ur0 = 1'b1;
                    else ur_other = 1'b1;
                end
                if (p == SW - 1) begin
                    if (!have) begin
                        checks++;
                        errors++;
                        $display("FAIL slot_unexpected: slot decoded %0h with no expected entry", acc);
                    end else begin
                        e = exp_q.pop_front();
                        check(e.right ? "word_right" : "word_left", {16'd0, acc}, {16'd0, e.word});
                        check("lrclk_slot", {31'd0, lr_bad}, 32'd0);
                        check("underrun_p0", {30'd0, ur_other, ur0}, {31'd0, e.ur});
                        check("pad_zero", {31'd0, pad}, 32'd0);
                    end
                    p = 0;
                end else begin
                    p++;
                end
            end
        end
    end

    initial begin : stimulus
        int ea;
        int eb;
        nreset        = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_is_left = 1'b1;
        bus.i_audio   = '0;

        // I2S, polarity 0: right word reaches the first right slot, left word the second left slot.
        do_reset(1'b1, 1'b0);
        push_slot(0, 16'h0000, 0);
        push_slot(1, 16'h0F0F, 0);
        push_slot(0, 16'hA5F0, 0);
        push_slot(1, HOLD ? 16'h0F0F : 16'h0000, 1);
        push_slot(0, HOLD ? 16'hA5F0 : 16'h0000, 1);
        fork
            begin send(1'b1, 16'hA5F0, ea); send(1'b0, 16'h0F0F, eb); end
            run_slots(5, 0);
        join

        // Left-justified single left word.
        do_reset(1'b0, 1'b0);
        push_slot(0, 16'h0000, 0);
        push_slot(1, 16'h0000, 1);
        push_slot(0, 16'h8001, 0);
        fork
            send(1'b1, 16'h8001, ea);
            run_slots(3, 0);
        join

        // Backpressure with polarity 1; reset lands mid-slot while the left register is still full.
        do_reset(1'b1, 1'b1);
        push_slot(0, 16'h0000, 0);
        push_slot(1, 16'h0000, 1);
        push_slot(0, 16'h1111, 0);
        push_slot(1, 16'h0000, 1);
        fork
            begin
                send(1'b1, 16'h1111, ea);
                check("bp_first_edge", 32'(ea), 32'd2);
                bus.i_is_left = 1'b0;
                @(negedge sclk);
                #1 check("bp_ready_right_free", {31'd0, bus.i_ready}, 32'd1);
                bus.i_is_left = 1'b1;
                #1 check("bp_ready_left_full", {31'd0, bus.i_ready}, 32'd0);
                send(1'b1, 16'h2222, eb);
                check("bp_second_edge", 32'(eb), 32'(2 * SW + 2));
            end
            run_slots(4, 10);
        join

        // Underrun after a single right word.
        do_reset(1'b1, 1'b0);
        push_slot(0, 16'h0000, 0);
        push_slot(1, 16'h7FFF, 0);
        push_slot(0, 16'h0000, 1);
        push_slot(1, HOLD ? 16'h7FFF : 16'h0000, 1);
        fork
            send(1'b0, 16'h7FFF, ea);
            run_slots(4, 0);
        join

        // 100-sample ramp, left-justified, polarity 1: every slot after the first is fed.
        do_reset(1'b0, 1'b1);
        push_slot(0, 16'h0000, 0);
        for (int k = 1; k <= 100; k++) begin
            if (k % 2 == 1) push_slot(1, ramp(k), 0);
            else push_slot(0, ramp(k - 2), 0);
        end
        fork
            for (int i = 0; i < 100; i++) send(i % 2 == 0, ramp(i), ea);
            run_slots(101, 0);
        join

        check("slots_consumed", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
